// File: rtl/usb_rx_nrzi_decoder.sv
// ---------------------------------------------------------------------------
// usb_rx_nrzi_decoder
// Receive-side USB line decoder. It synchronises D+/D- into the clk domain and
// NRZI-decodes one bit on every bit-centre strobe. It also removes stuffed
// zeros, flags bit-stuff violations and SE0 end-of-packet, and packs the data
// bits LSB-first into DATA_WIDTH-bit words for the packet FSM / FIFO.
// ---------------------------------------------------------------------------
module usb_rx_nrzi_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int STUFF_LEN   = 6,
   parameter int EOP_LEN     = 2,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  d_plus,
   input  logic                  d_minus,
   input  logic                  shift_enable,
   output logic                  d_orig,
   output logic                  bit_valid,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  byte_valid,
   output logic                  eop,
   output logic                  stuff_err,
   output logic                  align_err
);

   // Counter widths sized so each counter can hold its terminal value.
   localparam int OW = (STUFF_LEN  > 0) ? $clog2(STUFF_LEN + 1) : 1;
   localparam int SW = (EOP_LEN    > 0) ? $clog2(EOP_LEN + 1)   : 1;
   localparam int BW = $clog2(DATA_WIDTH);

   localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
   localparam logic [SW-1:0] EOP_MAX   = SW'(EOP_LEN);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   localparam logic [OW-1:0] ONES_ZERO = {OW{1'b0}};
   localparam logic [OW-1:0] ONES_ONE  = {{(OW-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0] SE0_ZERO  = {SW{1'b0}};
   localparam logic [SW-1:0] SE0_ONE   = {{(SW-1){1'b0}}, 1'b1};
   localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
   localparam logic [BW-1:0] BIT_ONE   = {{(BW-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

   // -----------------------------------------------------------------------
   // Synchronisers (reset to idle J: D+ high, D- low)
   // -----------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] dp_sync_q;
   logic [SYNC_STAGES-1:0] dm_sync_q;
   logic                   dp_s;
   logic                   dm_s;

   // Shift the raw line levels through the synchroniser chains.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dp_sync_q <= {SYNC_STAGES{1'b1}};
         dm_sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         dp_sync_q <= {dp_sync_q[SYNC_STAGES-2:0], d_plus};
         dm_sync_q <= {dm_sync_q[SYNC_STAGES-2:0], d_minus};
      end
   end

   assign dp_s = dp_sync_q[SYNC_STAGES-1];
   assign dm_s = dm_sync_q[SYNC_STAGES-1];

   // -----------------------------------------------------------------------
   // Decoder state
   // -----------------------------------------------------------------------
   logic                  prev_q,       prev_d;
   logic [OW-1:0]         ones_cnt_q,   ones_cnt_d;
   logic [SW-1:0]         se0_cnt_q,    se0_cnt_d;
   logic [BW-1:0]         bit_cnt_q,    bit_cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q,      shreg_d;
   logic [DATA_WIDTH-1:0] rx_data_q,    rx_data_d;
   logic                  d_orig_q,     d_orig_d;
   logic                  bit_valid_q,  bit_valid_d;
   logic                  byte_valid_q, byte_valid_d;
   logic                  eop_q,        eop_d;
   logic                  stuff_err_q,  stuff_err_d;
   logic                  align_err_q,  align_err_d;

   logic                  se0_s;
   logic                  b_s;
   logic [SW-1:0]         se0_inc_s;

   assign se0_s     = ~dp_s & ~dm_s;
   assign b_s       = (dp_s == prev_q);
   assign se0_inc_s = se0_cnt_q + SE0_ONE;

   // Next-state decode: handles SE0/EOP, NRZI decode, unstuffing and packing.
   always_comb begin
      prev_d       = prev_q;
      ones_cnt_d   = ones_cnt_q;
      se0_cnt_d    = se0_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      rx_data_d    = rx_data_q;
      d_orig_d     = d_orig_q;
      bit_valid_d  = 1'b0;
      byte_valid_d = 1'b0;
      eop_d        = 1'b0;
      stuff_err_d  = 1'b0;
      align_err_d  = 1'b0;

      if (shift_enable) begin
         if (se0_s) begin
            // SE0 carries no data; it only advances the EOP run.
            if (se0_cnt_q != EOP_MAX) begin
               se0_cnt_d = se0_inc_s;
               if (se0_inc_s == EOP_MAX) begin
                  eop_d       = 1'b1;
                  align_err_d = (bit_cnt_q != BIT_ZERO);
                  prev_d      = 1'b1;
                  ones_cnt_d  = ONES_ZERO;
                  bit_cnt_d   = BIT_ZERO;
                  shreg_d     = WORD_ZERO;
               end else begin
                  eop_d       = 1'b0;
               end
            end else begin
               // Saturated: a long SE0 reports its EOP only once.
               se0_cnt_d = se0_cnt_q;
            end
         end else begin
            se0_cnt_d = SE0_ZERO;
            prev_d    = dp_s;
            if (ones_cnt_q == STUFF_MAX) begin
               // Position of a stuffed bit: a 0 is dropped, a 1 is a violation.
               ones_cnt_d = ONES_ZERO;
               if (b_s) begin
                  stuff_err_d = 1'b1;
                  bit_cnt_d   = BIT_ZERO;
                  shreg_d     = WORD_ZERO;
               end else begin
                  stuff_err_d = 1'b0;
               end
            end else begin
               // Genuine data bit.
               ones_cnt_d  = b_s ? (ones_cnt_q + ONES_ONE) : ONES_ZERO;
               d_orig_d    = b_s;
               bit_valid_d = 1'b1;
               shreg_d     = {b_s, shreg_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == BIT_LAST) begin
                  rx_data_d    = shreg_d;
                  byte_valid_d = 1'b1;
                  bit_cnt_d    = BIT_ZERO;
               end else begin
                  bit_cnt_d    = bit_cnt_q + BIT_ONE;
               end
            end
         end
      end else begin
         // No strobe: everything holds and no pulses are generated.
         se0_cnt_d = se0_cnt_q;
      end
   end

   // Register decoder state and all outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_q       <= 1'b1;
         ones_cnt_q   <= ONES_ZERO;
         se0_cnt_q    <= SE0_ZERO;
         bit_cnt_q    <= BIT_ZERO;
         shreg_q      <= WORD_ZERO;
         rx_data_q    <= WORD_ZERO;
         d_orig_q     <= 1'b1;
         bit_valid_q  <= 1'b0;
         byte_valid_q <= 1'b0;
         eop_q        <= 1'b0;
         stuff_err_q  <= 1'b0;
         align_err_q  <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         ones_cnt_q   <= ones_cnt_d;
         se0_cnt_q    <= se0_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         rx_data_q    <= rx_data_d;
         d_orig_q     <= d_orig_d;
         bit_valid_q  <= bit_valid_d;
         byte_valid_q <= byte_valid_d;
         eop_q        <= eop_d;
         stuff_err_q  <= stuff_err_d;
         align_err_q  <= align_err_d;
      end
   end

   assign d_orig     = d_orig_q;
   assign bit_valid  = bit_valid_q;
   assign rx_data    = rx_data_q;
   assign byte_valid = byte_valid_q;
   assign eop        = eop_q;
   assign stuff_err  = stuff_err_q;
   assign align_err  = align_err_q;

endmodule

// File: tb/tb_usb_rx_nrzi_decoder.sv
// ---------------------------------------------------------------------------
// Bench for usb_rx_nrzi_decoder: directed scenarios plus randomised packets.
// A behavioural model predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_usb_rx_nrzi_decoder;
   localparam int SYNC_STAGES = 2;
   localparam int STUFF_LEN   = 6;
   localparam int EOP_LEN     = 2;
   localparam int DATA_WIDTH  = 8;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic dp_i = 1'b1;
   logic dm_i = 1'b0;
   logic se_i = 1'b0;
   logic d_orig, bit_valid, byte_valid, eop, stuff_err, align_err;
   logic [DATA_WIDTH-1:0] rx_data;

   always #5 clk = ~clk;

   usb_rx_nrzi_decoder #(
      .SYNC_STAGES(SYNC_STAGES), .STUFF_LEN(STUFF_LEN),
      .EOP_LEN(EOP_LEN), .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .clk(clk), .n_rst(n_rst), .d_plus(dp_i), .d_minus(dm_i),
      .shift_enable(se_i), .d_orig(d_orig), .bit_valid(bit_valid),
      .rx_data(rx_data), .byte_valid(byte_valid), .eop(eop),
      .stuff_err(stuff_err), .align_err(align_err)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Model state: line level seen last, length of current 1-run, SE0 run,
   // and the data bits of the partial word collected so far.
   int  m_prev, m_ones, m_se0;
   int  word_q[$];
   int  m_dorig, m_bv, m_byv, m_eop, m_serr, m_aerr;
   logic [DATA_WIDTH-1:0] m_rx;

   // Counters of DUT pulses, used by the directed checks.
   int c_bv = 0, c_byv = 0, c_eop = 0, c_serr = 0, c_aerr = 0, c_both = 0;
   logic [DATA_WIDTH-1:0] last_rx = '0;

   // Driver-side state
   logic lvl = 1'b1;
   int   st_ones = 0;

   function automatic void chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_prev = 1; m_ones = 0; m_se0 = 0; word_q.delete();
      m_dorig = 1; m_rx = '0;
      m_bv = 0; m_byv = 0; m_eop = 0; m_serr = 0; m_aerr = 0;
   endfunction

   function automatic void model_step(int dp, int dm, int se);
      int b;
      m_bv = 0; m_byv = 0; m_eop = 0; m_serr = 0; m_aerr = 0;
      if (se != 0) begin
         if (dp == 0 && dm == 0) begin
            if (m_se0 < EOP_LEN) begin
               m_se0++;
               if (m_se0 == EOP_LEN) begin
                  m_eop  = 1;
                  m_aerr = (word_q.size() != 0) ? 1 : 0;
                  m_prev = 1; m_ones = 0; word_q.delete();
               end
            end
         end else begin
            m_se0  = 0;
            b      = (dp == m_prev) ? 1 : 0;
            m_prev = dp;
            if (m_ones == STUFF_LEN) begin
               if (b == 1) begin
                  m_serr = 1;
                  word_q.delete();
               end
               m_ones = 0;
            end else begin
               m_ones  = (b == 1) ? m_ones + 1 : 0;
               m_dorig = b;
               m_bv    = 1;
               word_q.push_back(b);
               if (word_q.size() == DATA_WIDTH) begin
                  m_rx = '0;
                  foreach (word_q[i]) m_rx = m_rx | (DATA_WIDTH'(word_q[i]) << i);
                  m_byv = 1;
                  word_q.delete();
               end
            end
         end
      end
   endfunction

   // Advance the model on every edge, then compare the DUT shortly after it.
   always @(posedge clk) begin
      if (!n_rst) model_reset();
      else        model_step(int'(dp_i), int'(dm_i), int'(se_i));
      #1;
      chk("d_orig",     int'(d_orig),     m_dorig);
      chk("bit_valid",  int'(bit_valid),  m_bv);
      chk("rx_data",    int'(rx_data),    int'(m_rx));
      chk("byte_valid", int'(byte_valid), m_byv);
      chk("eop",        int'(eop),        m_eop);
      chk("stuff_err",  int'(stuff_err),  m_serr);
      chk("align_err",  int'(align_err),  m_aerr);
      if (bit_valid)  c_bv++;
      if (byte_valid) begin c_byv++; last_rx = rx_data; end
      if (eop)        c_eop++;
      if (stuff_err)  c_serr++;
      if (align_err)  c_aerr++;
      if (eop && align_err) c_both++;
   end

   // One line symbol: set the lines, let them settle through the
   // synchroniser, then strobe once. Starts and ends on a falling edge.
   task automatic sym(input logic dp, input logic dm);
      int p;
      p = $urandom_range(3, 5);
      dp_i = dp; dm_i = dm; se_i = 1'b0;
      repeat (p - 1) @(negedge clk);
      se_i = 1'b1;
      @(negedge clk);
      se_i = 1'b0;
   endtask

   task automatic nbit(input logic b);
      if (!b) lvl = ~lvl;
      sym(lvl, ~lvl);
   endtask

   task automatic send_bits(input logic [15:0] v, input int n, input bit stuff);
      for (int i = 0; i < n; i++) begin
         nbit(v[i]);
         if (v[i]) st_ones++; else st_ones = 0;
         if (stuff && st_ones == STUFF_LEN) begin
            nbit(1'b0);
            st_ones = 0;
         end
      end
   endtask

   task automatic send_eop();
      sym(1'b0, 1'b0);
      sym(1'b0, 1'b0);
      dp_i = 1'b1; dm_i = 1'b0;
      repeat (3) @(negedge clk);
      lvl = 1'b1; st_ones = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, y0, s0, e0, a0, x0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_d_orig", int'(d_orig), 1);
      chk("rst_rx_data", int'(rx_data), 0);
      chk("rst_pulses", int'({bit_valid, byte_valid, eop, stuff_err, align_err}), 0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      // Four J strobes: four decoded 1s.
      b0 = c_bv; y0 = c_byv; s0 = c_serr;
      for (int i = 0; i < 4; i++) sym(1'b1, 1'b0);
      chk("j4_bit_valid", c_bv - b0, 4);
      chk("j4_d_orig", int'(d_orig), 1);
      chk("j4_byte_valid", c_byv - y0, 0);
      chk("j4_stuff_err", c_serr - s0, 0);
      a0 = c_aerr;
      send_eop();
      chk("j4_eop_align", c_aerr - a0, 1);

      // 0xA5 from idle.
      b0 = c_bv; y0 = c_byv;
      send_bits(16'h00A5, 8, 1'b1);
      chk("a5_bits", c_bv - b0, 8);
      chk("a5_bytes", c_byv - y0, 1);
      chk("a5_rx", int'(last_rx), 8'hA5);
      chk("a5_model", int'(m_rx), 8'hA5);
      send_eop();

      // 0xFF needs one stuffed zero after six 1s.
      b0 = c_bv; y0 = c_byv;
      send_bits(16'h00FF, 8, 1'b1);
      chk("ff_bits", c_bv - b0, 8);
      chk("ff_rx", int'(last_rx), 8'hFF);
      chk("ff_bytes", c_byv - y0, 1);
      send_eop();

      // Seven 1s without stuffing: violation, then a fresh word.
      b0 = c_bv; s0 = c_serr;
      send_bits(16'h007F, 7, 1'b0);
      chk("serr_count", c_serr - s0, 1);
      chk("serr_bits", c_bv - b0, 6);
      st_ones = 0;
      y0 = c_byv;
      send_bits(16'h005A, 8, 1'b1);
      chk("after_serr_rx", int'(last_rx), 8'h5A);
      chk("after_serr_bytes", c_byv - y0, 1);
      send_eop();

      // Three bits then EOP: eop and align_err together.
      e0 = c_eop; a0 = c_aerr; x0 = c_both;
      send_bits(16'h0005, 3, 1'b1);
      send_eop();
      chk("part_eop", c_eop - e0, 1);
      chk("part_align", c_aerr - a0, 1);
      chk("part_both", c_both - x0, 1);
      send_bits(16'h0096, 8, 1'b1);
      chk("part_next_rx", int'(last_rx), 8'h96);
      send_eop();

      // Reset mid-word with five bits (last one 0) collected.
      send_bits(16'h000B, 5, 1'b1);
      chk("pre_rst_d_orig", int'(d_orig), 0);
      n_rst = 1'b0; dp_i = 1'b1; dm_i = 1'b0;
      #1;
      chk("mid_rst_d_orig", int'(d_orig), 1);
      chk("mid_rst_rx", int'(rx_data), 0);
      chk("mid_rst_pulses", int'({bit_valid, byte_valid, eop, stuff_err, align_err}), 0);
      repeat (3) @(negedge clk);
      n_rst = 1'b1; lvl = 1'b1; st_ones = 0;
      @(negedge clk);
      y0 = c_byv;
      send_bits(16'h003C, 8, 1'b1);
      chk("post_rst_rx", int'(last_rx), 8'h3C);
      chk("post_rst_bytes", c_byv - y0, 1);
      send_eop();

      // Random packets: stuffed bytes, odd tails, violations, SE1 glitches.
      for (int p = 0; p < 40; p++) begin
         int nb;
         nb = $urandom_range(1, 3);
         for (int k = 0; k < nb; k++) send_bits(16'($urandom_range(0, 255)), 8, 1'b1);
         if ($urandom_range(0, 4) == 0) send_bits(16'($urandom_range(0, 255)), $urandom_range(1, 7), 1'b1);
         if ($urandom_range(0, 5) == 0) begin send_bits(16'h007F, 7, 1'b0); st_ones = 0; end
         if ($urandom_range(0, 7) == 0) begin sym(1'b1, 1'b1); lvl = 1'b1; st_ones = 0; end
         send_eop();
      end

      // Unconstrained line noise, then a clean packet.
      for (int i = 0; i < 150; i++) sym(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      send_eop();
      send_bits(16'h00C3, 8, 1'b1);
      chk("final_rx", int'(last_rx), 8'hC3);
      send_eop();
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
